// File: rtl/samp_checker.sv
// Scoreboard behind the DQ sampler: queues expected byte/mask pairs, compares the
// sample stream in order, and reports pass/fail/timeout/orphan events.
module samp_checker #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  EXP_DATA,
   input  logic [7:0]  EXP_MASK,
   input  logic        EXP_PUSH,
   output logic        EXP_FULL,
   input  logic [7:0]  SAMP_DATA,
   input  logic        SAMP_VALID,
   input  logic        CLR_CNT,
   output logic [15:0] PASS_CNT,
   output logic [15:0] FAIL_CNT,
   output logic [15:0] TMO_CNT,
   output logic [15:0] ORPHAN_CNT,
   output logic        OVF,
   output logic        ERR_PULSE,
   output logic [1:0]  ERR_CODE,
   output logic [7:0]  ERR_DATA,
   output logic        BUSY
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT);

   typedef enum logic {EMPTY, ARMED} state_t;
   state_t state_q, state_d;

   logic [7:0]    data_mem_q [FIFO_DEPTH];
   logic [7:0]    mask_mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0]   pass_cnt_q, pass_cnt_d;
   logic [15:0]   fail_cnt_q, fail_cnt_d;
   logic [15:0]   tmo_cnt_q, tmo_cnt_d;
   logic [15:0]   orphan_cnt_q, orphan_cnt_d;
   logic          ovf_q, ovf_d;
   logic          err_pulse_q, err_pulse_d;
   logic [1:0]    err_code_q, err_code_d;
   logic [7:0]    err_data_q, err_data_d;

   logic          full, head_valid, push_ok;
   logic          do_cmp, do_orphan, do_tmo, do_pop, mismatch;
   logic [7:0]    head_data, head_mask, diff;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == '1) ? v : v + 16'd1;
   endfunction

   always_comb begin
      full       = (count_q == CW'(FIFO_DEPTH));
      head_valid = (state_q == ARMED);
      push_ok    = EXP_PUSH && !full;
      head_data  = data_mem_q[rd_ptr_q];
      head_mask  = mask_mem_q[rd_ptr_q];
      diff       = (SAMP_DATA ^ head_data) & head_mask;
      do_cmp     = head_valid && SAMP_VALID;
      mismatch   = do_cmp && (diff != '0);
      do_orphan  = !head_valid && SAMP_VALID;
      // A sample in the would-be timeout cycle wins over the timeout.
      do_tmo     = head_valid && !SAMP_VALID && (timer_q == TW'(TIMEOUT - 1));
      do_pop     = do_cmp || do_tmo;
   end

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      unique case ({push_ok, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      timer_d = (!head_valid || do_pop) ? '0 : timer_q + TW'(1);

      state_d = state_q;
      unique case (state_q)
         EMPTY:   if (push_ok) state_d = ARMED;
         ARMED:   if (do_pop && (count_q == CW'(1)) && !push_ok) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      pass_cnt_d   = pass_cnt_q;
      fail_cnt_d   = fail_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      orphan_cnt_d = orphan_cnt_q;
      ovf_d        = ovf_q | (EXP_PUSH && full);
      if (do_cmp && !mismatch) pass_cnt_d   = sat_inc(pass_cnt_q);
      if (mismatch)            fail_cnt_d   = sat_inc(fail_cnt_q);
      if (do_tmo)              tmo_cnt_d    = sat_inc(tmo_cnt_q);
      if (do_orphan)           orphan_cnt_d = sat_inc(orphan_cnt_q);
      if (CLR_CNT) begin
         pass_cnt_d   = '0;
         fail_cnt_d   = '0;
         tmo_cnt_d    = '0;
         orphan_cnt_d = '0;
         ovf_d        = 1'b0;
      end

      err_pulse_d = 1'b0;
      err_code_d  = 2'b00;
      err_data_d  = err_data_q;
      if (mismatch) begin
         err_pulse_d = 1'b1;
         err_code_d  = 2'b01;
         err_data_d  = diff;
      end else if (do_tmo) begin
         err_pulse_d = 1'b1;
         err_code_d  = 2'b10;
         err_data_d  = head_data;
      end else if (do_orphan) begin
         err_pulse_d = 1'b1;
         err_code_d  = 2'b11;
         err_data_d  = SAMP_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= EMPTY;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         timer_q      <= '0;
         pass_cnt_q   <= '0;
         fail_cnt_q   <= '0;
         tmo_cnt_q    <= '0;
         orphan_cnt_q <= '0;
         ovf_q        <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_code_q   <= '0;
         err_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         timer_q      <= timer_d;
         pass_cnt_q   <= pass_cnt_d;
         fail_cnt_q   <= fail_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         orphan_cnt_q <= orphan_cnt_d;
         ovf_q        <= ovf_d;
         err_pulse_q  <= err_pulse_d;
         err_code_q   <= err_code_d;
         err_data_q   <= err_data_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok) begin
         data_mem_q[wr_ptr_q] <= EXP_DATA;
         mask_mem_q[wr_ptr_q] <= EXP_MASK;
      end
   end

   assign EXP_FULL   = full;
   assign BUSY       = (count_q != '0);
   assign PASS_CNT   = pass_cnt_q;
   assign FAIL_CNT   = fail_cnt_q;
   assign TMO_CNT    = tmo_cnt_q;
   assign ORPHAN_CNT = orphan_cnt_q;
   assign OVF        = ovf_q;
   assign ERR_PULSE  = err_pulse_q;
   assign ERR_CODE   = err_code_q;
   assign ERR_DATA   = err_data_q;

endmodule

// File: tb/tb_samp_checker.sv
// Bench for samp_checker: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_samp_checker;

   localparam int DEPTH = 8;
   localparam int TMO   = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  exp_data, exp_mask, samp_data;
   logic        exp_push, samp_valid, clr_cnt;
   logic        exp_full, ovf, err_pulse, busy;
   logic [15:0] pass_cnt, fail_cnt, tmo_cnt, orphan_cnt;
   logic [1:0]  err_code;
   logic [7:0]  err_data;

   always #5 clk = ~clk;

   samp_checker #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .CLK(clk), .RST(rst),
      .EXP_DATA(exp_data), .EXP_MASK(exp_mask), .EXP_PUSH(exp_push), .EXP_FULL(exp_full),
      .SAMP_DATA(samp_data), .SAMP_VALID(samp_valid), .CLR_CNT(clr_cnt),
      .PASS_CNT(pass_cnt), .FAIL_CNT(fail_cnt), .TMO_CNT(tmo_cnt), .ORPHAN_CNT(orphan_cnt),
      .OVF(ovf), .ERR_PULSE(err_pulse), .ERR_CODE(err_code), .ERR_DATA(err_data), .BUSY(busy)
   );

   typedef struct {
      logic [7:0] d;
      logic [7:0] m;
   } ent_t;

   ent_t       q[$];
   int         age;
   int         m_pass, m_fail, m_tmo, m_orph;
   bit         m_ovf, m_ep;
   logic [1:0] m_ec;
   logic [7:0] m_ed;
   int         errors = 0;
   int         checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   // Reference: entries wait in a queue; the head ages one per idle cycle and expires
   // on its TMO-th idle cycle at the head.
   task automatic model_step();
      logic [7:0] df;
      bit         full_pre;
      ent_t       e;
      if (rst) begin
         q.delete();
         age = 0;
         m_pass = 0; m_fail = 0; m_tmo = 0; m_orph = 0;
         m_ovf = 0; m_ep = 0; m_ec = 2'b00; m_ed = 8'h00;
         return;
      end
      full_pre = (q.size() == DEPTH);
      m_ep = 0;
      m_ec = 2'b00;
      if (samp_valid) begin
         if (q.size() > 0) begin
            df = (samp_data ^ q[0].d) & q[0].m;
            if (df == 8'h00) m_pass = sat(m_pass);
            else begin
               m_fail = sat(m_fail); m_ep = 1; m_ec = 2'b01; m_ed = df;
            end
            q.delete(0);
            age = 0;
         end else begin
            m_orph = sat(m_orph); m_ep = 1; m_ec = 2'b11; m_ed = samp_data;
         end
      end else if (q.size() > 0) begin
         if (age == TMO - 1) begin
            m_tmo = sat(m_tmo); m_ep = 1; m_ec = 2'b10; m_ed = q[0].d;
            q.delete(0);
            age = 0;
         end else age++;
      end
      if (exp_push) begin
         if (full_pre) m_ovf = 1;
         else begin
            e.d = exp_data; e.m = exp_mask;
            q.push_back(e);
         end
      end
      if (clr_cnt) begin
         m_pass = 0; m_fail = 0; m_tmo = 0; m_orph = 0; m_ovf = 0;
      end
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      chk("pass_cnt", pass_cnt, m_pass);
      chk("fail_cnt", fail_cnt, m_fail);
      chk("tmo_cnt", tmo_cnt, m_tmo);
      chk("orphan_cnt", orphan_cnt, m_orph);
      chk("ovf", ovf, m_ovf);
      chk("err_pulse", err_pulse, m_ep);
      chk("err_code", err_code, m_ec);
      chk("err_data", err_data, m_ed);
      chk("busy", busy, q.size() != 0);
      chk("exp_full", exp_full, q.size() == DEPTH);
   end

   task automatic cyc(input bit ps, input logic [7:0] pd, input logic [7:0] pm,
                      input bit sv, input logic [7:0] sd, input bit cl, input bit rs);
      exp_push = ps; exp_data = pd; exp_mask = pm;
      samp_valid = sv; samp_data = sd; clr_cnt = cl; rst = rs;
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] d, input logic [7:0] m);
      cyc(1, d, m, 0, 8'h00, 0, 0);
   endtask

   task automatic samp(input logic [7:0] d);
      cyc(0, 8'h00, 8'h00, 1, d, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
   endtask

   task automatic clr();
      cyc(0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
   endtask

   int         sp, pp, r;
   bit         r_ps, r_sv, r_cl, r_rs;
   logic [7:0] r_pd, r_pm, r_sd, tmp;

   initial begin
      rst = 1; exp_push = 0; exp_data = 0; exp_mask = 0;
      samp_valid = 0; samp_data = 0; clr_cnt = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_pass", pass_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", exp_full, 0);
      chk("rst_err_data", err_data, 0);
      rst = 0;
      idle(2);

      // match
      push(8'hA5, 8'hFF);
      idle(2);
      samp(8'hA5);
      chk("match_pass", pass_cnt, 1);
      chk("match_pulse", err_pulse, 0);
      chk("match_busy", busy, 0);

      // masked compare
      clr();
      push(8'hA5, 8'h0F);
      push(8'hA5, 8'h0F);
      samp(8'h55);
      samp(8'h57);
      chk("mask_pass", pass_cnt, 1);
      chk("mask_fail", fail_cnt, 1);
      chk("mask_code", err_code, 2'b01);
      chk("mask_data", err_data, 8'h02);

      // timeout, then sample on the last allowed cycle
      clr();
      push(8'h3C, 8'hFF);
      idle(63);
      chk("tmo_early_pulse", err_pulse, 0);
      chk("tmo_early_cnt", tmo_cnt, 0);
      idle(1);
      chk("tmo_pulse", err_pulse, 1);
      chk("tmo_code", err_code, 2'b10);
      chk("tmo_data", err_data, 8'h3C);
      chk("tmo_cnt", tmo_cnt, 1);
      chk("tmo_busy", busy, 0);
      idle(1);
      chk("tmo_code_idle", err_code, 2'b00);
      chk("tmo_data_hold", err_data, 8'h3C);
      push(8'h3C, 8'hFF);
      idle(63);
      samp(8'h3C);
      chk("late_pass", pass_cnt, 1);
      chk("late_tmo", tmo_cnt, 1);
      chk("late_pulse", err_pulse, 0);

      // orphans
      clr();
      samp(8'h11);
      chk("orph_cnt", orphan_cnt, 1);
      chk("orph_code", err_code, 2'b11);
      chk("orph_data", err_data, 8'h11);
      cyc(1, 8'h22, 8'hFF, 1, 8'h22, 0, 0);
      chk("orph2_cnt", orphan_cnt, 2);
      chk("orph2_busy", busy, 1);
      idle(64);
      chk("orph2_tmo", tmo_cnt, 1);
      chk("orph2_tmo_data", err_data, 8'h22);

      // full / overflow
      clr();
      for (int i = 0; i < 9; i++) begin
         tmp = 8'(i);
         push(tmp, 8'hFF);
         if (i == 6) chk("full_6", exp_full, 0);
         if (i == 7) begin
            chk("full_7", exp_full, 1);
            chk("ovf_7", ovf, 0);
         end
         if (i == 8) chk("ovf_8", ovf, 1);
      end
      for (int i = 0; i < 8; i++) begin
         tmp = 8'(i);
         samp(tmp);
      end
      chk("drain_pass", pass_cnt, 8);
      chk("drain_fail", fail_cnt, 0);
      chk("drain_busy", busy, 0);

      // clear colliding with a mismatch
      push(8'h10, 8'hFF);
      cyc(0, 8'h00, 8'h00, 1, 8'h11, 1, 0);
      chk("clr_fail", fail_cnt, 0);
      chk("clr_ovf", ovf, 0);
      chk("clr_pulse", err_pulse, 1);
      chk("clr_code", err_code, 2'b01);
      chk("clr_data", err_data, 8'h01);

      // reset with entries queued
      push(8'h01, 8'hFF);
      push(8'h02, 8'hFF);
      push(8'h03, 8'hFF);
      cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1);
      chk("mrst_busy", busy, 0);
      chk("mrst_err_data", err_data, 0);
      chk("mrst_pulse", err_pulse, 0);
      idle(70);
      chk("mrst_tmo", tmo_cnt, 0);

      // randomized traffic: busy phase, then sparse phase that exercises timeouts
      for (int n = 0; n < 2600; n++) begin
         sp = (n < 1600) ? 40 : 4;
         pp = (n < 1600) ? 45 : 8;
         r_ps = ($urandom_range(0, 99) < pp);
         r_pd = 8'($urandom);
         r = $urandom_range(0, 7);
         r_pm = (r == 0) ? 8'h00 : (r < 3) ? 8'hFF : 8'($urandom);
         r_sv = ($urandom_range(0, 99) < sp);
         if (q.size() > 0 && $urandom_range(0, 3) != 0)
            r_sd = q[0].d ^ (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
         else
            r_sd = 8'($urandom);
         r_cl = ($urandom_range(0, 199) == 0);
         r_rs = ($urandom_range(0, 599) == 0);
         cyc(r_ps, r_pd, r_pm, r_sv, r_sd, r_cl, r_rs);
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/samp_checker.md
# samp_checker

Scoreboard stage directly downstream of the DQ sampler. It holds a queue of expected bytes with bit masks, pushed by the test sequencer each time it issues a strobe. It consumes the sampler's `SAMP_DATA`/`SAMP_VALID` stream, compares each sample against the queue head in order, and keeps pass/fail/timeout/orphan counters plus a per-event error report. A timeout flags strobes whose sample never arrived, which happens when the sampler returns `SAMP_VALID=0` for invalid DQ data.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: expectation queue depth; a power of 2, 2..64.
- `TIMEOUT`, default 64: cycles an entry may sit at the queue head without a sample; minimum 34, which covers the sampler's worst-case forward latency of 32 cycles plus margin.

Ports:
- `CLK`, in, 1: the block's single clock.
- `RST`, in, 1: synchronous, active-high reset.
- `EXP_DATA`, in, 8: expected byte.
- `EXP_MASK`, in, 8: compare mask; 1 = bit is checked.
- `EXP_PUSH`, in, 1: enqueue `EXP_DATA`/`EXP_MASK` this cycle.
- `EXP_FULL`, out, 1: queue holds `FIFO_DEPTH` entries.
- `SAMP_DATA`, in, 8: sampled byte from the sampler.
- `SAMP_VALID`, in, 1: single-cycle sample-valid.
- `CLR_CNT`, in, 1: clears the counters and `OVF`.
- `PASS_CNT`, out, 16: matched samples.
- `FAIL_CNT`, out, 16: mismatched samples.
- `TMO_CNT`, out, 16: expectations that timed out.
- `ORPHAN_CNT`, out, 16: samples that arrived with the queue empty.
- `OVF`, out, 1: sticky flag; a push was dropped because the queue was full.
- `ERR_PULSE`, out, 1: one-cycle error report strobe.
- `ERR_CODE`, out, 2: error type; 01 mismatch, 10 timeout, 11 orphan; 00 when no error.
- `ERR_DATA`, out, 8: error detail (see Operation).
- `BUSY`, out, 1: queue non-empty.

## Operation
Expectation queue:
- Circular FIFO with write pointer, read pointer and occupancy count. `count` is one bit wider than the pointer.
- Push: `EXP_PUSH && !EXP_FULL` writes the entry at the tail.
- Push while full: the entry is dropped and `OVF` is set, even if a pop happens in the same cycle. The drop is not counted in any counter.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- A push is visible at the head the cycle after it is written.

Compare (queue non-empty, `SAMP_VALID=1`):
- Compute `diff = (SAMP_DATA ^ head.data) & head.mask`.
- `diff == 0`: increment `PASS_CNT`.
- Otherwise: increment `FAIL_CNT`, `ERR_CODE=01`, `ERR_DATA=diff`.
- In both cases the head is popped and the timer is cleared.
- A mask of 0x00 always passes.

Orphan (queue empty, `SAMP_VALID=1`):
- Increment `ORPHAN_CNT`, `ERR_CODE=11`, `ERR_DATA=SAMP_DATA`.
- This includes a push into an empty queue in the same cycle as the sample. The pushed entry remains queued and is later matched or timed out.

Timeout timer, width `clog2(TIMEOUT)`:
- Held at 0 while the queue is empty.
- Counts every cycle the queue is non-empty and `SAMP_VALID=0`.
- When `timer == TIMEOUT-1` and `SAMP_VALID=0`: pop the head, increment `TMO_CNT`, `ERR_CODE=10`, `ERR_DATA=head.data`, timer to 0.
- A sample arriving in the same cycle as a would-be timeout is compared normally; no timeout is raised.

Counters:
- All four counters saturate at 0xFFFF.
- `CLR_CNT` zeroes all four counters and `OVF` on the next edge. It takes priority over a same-cycle increment or overflow.
- `CLR_CNT` does not affect the queue or the timer.

State summary:
- EMPTY (`count==0`) goes to ARMED on an accepted push.
- ARMED goes to EMPTY on a pop (match, mismatch or timeout) when `count==1` and there is no simultaneous push.

## Timing
- `ERR_PULSE`, `ERR_CODE`, `ERR_DATA` and all counters are registered and update on the edge that samples the event; they are visible one cycle after the `SAMP_VALID` cycle or the timeout cycle.
- `ERR_PULSE` is high for exactly one cycle per error. `ERR_CODE` returns to 00 and `ERR_DATA` holds its last value when no error occurs.
- `EXP_FULL` and `BUSY` decode the registered count, so they are valid in the same cycle.
- Back-to-back `SAMP_VALID` is accepted every cycle; throughput is one compare per cycle.
- Reset: all counters, `OVF`, `ERR_PULSE`, `ERR_CODE`, `ERR_DATA`, `BUSY` and `EXP_FULL` are 0; pointers, count and timer are 0. Reset mid-operation discards queued entries without raising timeouts.

## Test plan
- Match: push `0xA5`/`0xFF`; 3 cycles later sample `0xA5` -> `PASS_CNT=1` next cycle, `ERR_PULSE` stays 0, `BUSY` drops to 0.
- Masked compare: push `0xA5`/`0x0F` and `0xA5`/`0x0F`; sample `0x55` then `0x57` -> `PASS_CNT=1`, `FAIL_CNT=1`, `ERR_CODE=01`, `ERR_DATA=0x02`.
- Timeout (`TIMEOUT=64`): push `0x3C`, no sample -> exactly 64 cycles after the entry reaches the head, `ERR_PULSE` with `ERR_CODE=10`, `ERR_DATA=0x3C`, `TMO_CNT=1`. Repeat with the sample on cycle 63 -> pass, no timeout.
- Orphan: sample `0x11` with the queue empty -> `ORPHAN_CNT=1`, `ERR_CODE=11`, `ERR_DATA=0x11`. Same-cycle push `0x22` plus sample `0x22` -> orphan, then the entry times out.
- Full/overflow (depth 8): push 9 entries `0x00..0x08` -> `EXP_FULL` after the 8th, the 9th is dropped, `OVF=1`; then 8 matching samples -> `PASS_CNT=8`, `BUSY=0`.
- Clear/reset: `CLR_CNT` in the same cycle as a mismatch -> `FAIL_CNT=0`, `ERR_PULSE` still fires. Assert `RST` with 3 entries queued -> all outputs 0 next cycle, no timeout afterwards.
